// File: rtl/instr_decode_stage.sv
// Decode stage: one-entry output register between fetch and imm_mux/execute.
// Classifies each instruction into an immediate format, register indices, rd write-enable and an illegal flag.
module instr_decode_stage #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ILEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic [5:0]      out_imm_sel,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_illegal
);

  localparam logic [5:0] IMM_I     = 6'b000000;
  localparam logic [5:0] IMM_S     = 6'b001001;
  localparam logic [5:0] IMM_B     = 6'b010010;
  localparam logic [5:0] IMM_U     = 6'b011011;
  localparam logic [5:0] IMM_J     = 6'b100100;
  localparam logic [5:0] IMM_SHAMT = 6'b101101;
  localparam logic [5:0] IMM_ZIMM  = 6'b110110;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [4:0] w_rd;
  logic [5:0] w_imm_sel;
  logic       w_writes_rd;
  logic       w_illegal;
  logic       w_capture;

  assign w_opcode  = in_instr[6:0];
  assign w_funct3  = in_instr[14:12];
  assign w_rd      = in_instr[11:7];
  assign in_ready  = !out_valid || out_ready;
  assign w_capture = in_valid && in_ready;

  // Opcode/funct3 classification; every valid opcode ends in 2'b11, so a bad length field lands in default.
  always_comb begin
    w_imm_sel   = IMM_I;
    w_writes_rd = 1'b0;
    w_illegal   = 1'b0;
    case (w_opcode)
      7'b0110111, 7'b0010111: begin
        w_imm_sel   = IMM_U;
        w_writes_rd = 1'b1;
      end
      7'b1101111: begin
        w_imm_sel   = IMM_J;
        w_writes_rd = 1'b1;
      end
      7'b1100111: begin
        if (w_funct3 == 3'b000) begin
          w_writes_rd = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end
      7'b1100011: w_imm_sel = IMM_B;
      7'b0000011: w_writes_rd = 1'b1;
      7'b0001111: w_writes_rd = 1'b0;
      7'b0100011: w_imm_sel = IMM_S;
      7'b0010011, 7'b0011011: begin
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
          w_imm_sel = IMM_SHAMT;
        end else begin
          w_imm_sel = IMM_I;
        end
        w_writes_rd = 1'b1;
      end
      7'b0110011, 7'b0111011: w_writes_rd = 1'b1;
      7'b1110011: begin
        if (w_funct3[2]) begin
          w_imm_sel = IMM_ZIMM;
        end else begin
          w_imm_sel = IMM_I;
        end
        w_writes_rd = (w_funct3 != 3'b000);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Output register: reset > flush > capture > drain; payload held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_instr   <= '0;
      out_imm_sel <= IMM_I;
      out_rs1     <= 5'd0;
      out_rs2     <= 5'd0;
      out_rd      <= 5'd0;
      out_rd_we   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_capture) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_instr   <= in_instr;
      out_imm_sel <= w_imm_sel;
      out_rs1     <= in_instr[19:15];
      out_rs2     <= in_instr[24:20];
      out_rd      <= w_rd;
      out_rd_we   <= w_writes_rd && (w_rd != 5'd0);
      out_illegal <= w_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule
